gpu_bus_bridge: RTL and testbench
=================================

Name: gpu_bus_bridge

Overview:
Second-generation CPU-to-GPU register bridge. A 3-bit CPU register window exposes two independent auto-incrementing data ports. Writes are posted through a small write FIFO onto a single request/acknowledge memory bus. The GPU memory arbiter downstream decodes `mem_addr` into the tile, attribute and colour regions.

Parameters:
- ADDR_W, 16: width of the port address pointers and `mem_addr`.
- FIFO_DEPTH, 4: write FIFO entries; power of 2, minimum 2.
- INC_RESET, 1: reset value of both increment registers.

Ports:
- clk  in  1  system clock; every CPU and memory signal is synchronous to it.
- rst  in  1  synchronous, active-low reset.
- cpu_strobe  in  1  one-cycle pulse per CPU access, generated by the upstream synchroniser.
- cpu_cs_n  in  1  chip select, active-low; qualifies `cpu_strobe`.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  3  register index.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  registered read data.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = write request, 0 = read request.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  8  write data.
- mem_ack  in  1  one-cycle request completion.
- mem_rdata  in  8  read data, valid in the `mem_ack` cycle.

Behaviour:
- An access occurs when `cpu_strobe` is 1 and `cpu_cs_n` is 0. At most one access per cycle.
- Register map:
  - 0 CTRL: bit0 SEL selects which port registers 1-3 address; bit7 written 1 clears OVF (self-clearing). Reads return {OVF, 6'b0, SEL}.
  - 1 INC: 8-bit unsigned increment of the selected port. 0 = no increment.
  - 2 ADDR_LO: selected pointer [7:0].
  - 3 ADDR_HI: selected pointer [ADDR_W-1:8]. Excess write bits are ignored; excess read bits return 0.
  - 4 DATA0 / 5 DATA1: data window of port 0 / port 1.
  - 6 STATUS: bit0 FIFO full, bit1 FIFO empty, bit2 PF0 valid, bit3 PF1 valid, bit4 OVF.
  - 7: reserved. Writes are ignored, reads return 0.
- Read latency: `cpu_rdata` updates on the clock edge after the access and holds until the next read.
- Write to DATAn:
  - FIFO not full: push {ptr_n, cpu_wdata}, then ptr_n <= ptr_n + inc_n modulo 2^ADDR_W.
  - FIFO full: data dropped, ptr_n unchanged, OVF set (sticky).
  - Fullness is evaluated before any same-cycle pop, so a push in a full cycle is dropped even if `mem_ack` pops.
- Memory sequencer states:
  - IDLE: FIFO non-empty -> WR (highest priority). Else, if a port has a pending prefetch -> RD; port 0 before port 1.
  - WR: `mem_req`=1, `mem_we`=1, head entry on `mem_addr`/`mem_wdata`. On `mem_ack`: pop, go to IDLE.
  - RD: `mem_req`=1, `mem_we`=0, `mem_addr` = the selected port's pointer captured at issue. On `mem_ack`: PFn <= `mem_rdata`, valid_n <= 1, pending_n <= 0, go to IDLE.
  - `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are registered and stable while `mem_req`=1.
  - A new request is issued at the earliest one cycle after an ack; no back-to-back requests.
- Prefetch (readback builds only):
  - Writing ADDR_LO or ADDR_HI of port n: valid_n <= 0, pending_n <= 1.
  - Any DATA write push: both valid bits cleared and both pending bits set. Refetch happens only once the FIFO is empty, because writes have priority.
  - If a pointer changes while its RD is outstanding: the returning data is discarded and pending stays 1.
  - Read DATAn: `cpu_rdata` <= PFn, regardless of valid; software polls STATUS. Then ptr_n += inc_n, valid_n <= 0, pending_n <= 1.
- Reads of DATAn in non-readback builds return 0 but still advance ptr_n.
- Reset (rst=0 at an edge) values:
  - `cpu_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Pointers 0, INC = INC_RESET, SEL=0, OVF=0.
  - FIFO empty, PF data 0, valid 0, pending 0, state IDLE.
- Reset mid-request: `mem_req` drops at that edge. The downstream arbiter must tolerate an abandoned request.

Optional Feature:
GPU_BUS_BRIDGE_READBACK_EN
- Defined: prefetch registers, pending/valid logic and the RD state are present.
- Undefined: no RD state; `mem_we` is constantly 1 when `mem_req`=1. DATA reads return 0 and increment the pointer. STATUS bits 2-3 read 0.

Decomposition:
- Shared package `gpu_pkg`: register index constants (REG_CTRL ... REG_STATUS), STATUS/CTRL bit positions, and a sequencer state enum (IDLE, WR, RD).
- One sub-module: `gpu_write_fifo`, parametrised on FIFO_DEPTH and entry width. It provides push/pop/full/empty with same-cycle push+pop when not full.
- Pointer/increment logic and the sequencer stay in the top module.

Test Plan:
- Reset, then write ADDR_LO=0x00, ADDR_HI=0x18, INC=2, then DATA0 writes 0xAA, 0xBB with `mem_ack` after 1 cycle -> `mem_req`/`mem_we` writes to 0x1800=0xAA and 0x1802=0xBB; port 0 pointer reads back 0x1804.
- Hold `mem_ack`=0 and perform 5 DATA1 writes with FIFO_DEPTH=4 -> first 4 queued, STATUS=0x11 (full, OVF). Write CTRL=0x80 -> OVF clears.
- Port 0 pointer=0xFFFF, INC=1, DATA0 write -> pointer wraps to 0x0000.
- READBACK_EN, memory returns 0x5A at 0x0100: set ADDR=0x0100, poll STATUS bit2=1, read DATA0 -> `cpu_rdata`=0x5A one cycle later, pointer 0x0101, a new RD issued for 0x0101.
- READBACK_EN, DATA1 write queued while FIFO non-empty -> no RD is issued until the FIFO drains, then prefetch of both ports in order 0, 1.
- Drive rst=0 while `mem_req`=1 -> next edge: `mem_req`=0, FIFO empty, INC=INC_RESET, STATUS=0x02.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared definitions for the CPU-to-GPU register bridge.
//   - CPU register window indices (REG_CTRL .. REG_STATUS)
//   - CTRL and STATUS bit positions
//   - memory sequencer state encoding
package gpu_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_INC     = 3'd1;
    localparam logic [2:0] REG_ADDR_LO = 3'd2;
    localparam logic [2:0] REG_ADDR_HI = 3'd3;
    localparam logic [2:0] REG_DATA0   = 3'd4;
    localparam logic [2:0] REG_DATA1   = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;

    localparam int CTRL_SEL_BIT = 0;
    localparam int CTRL_OVF_BIT = 7;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_PF0_BIT   = 2;
    localparam int ST_PF1_BIT   = 3;
    localparam int ST_OVF_BIT   = 4;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_WR   = 2'd1,
        SEQ_RD   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/gpu_write_fifo.sv
// gpu_write_fifo: small synchronous FIFO holding posted CPU writes.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   push/push_data write side; a push while full is ignored
//   pop            remove head entry (ignored when empty)
//   head           current head entry (valid when !empty)
//   full, empty    occupancy flags, registered-state based
// Push and pop may occur in the same cycle when the FIFO is not full.
module gpu_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra wrap bit distinguishes full from empty.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/gpu_bus_bridge.sv
// gpu_bus_bridge: CPU register window with two auto-incrementing data
// ports, posting writes through a FIFO onto a req/ack memory bus.
// Optional macro GPU_BUS_BRIDGE_READBACK_EN adds per-port prefetch
// registers and the memory read path.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   cpu_strobe, cpu_cs_n, cpu_rw  CPU access qualifiers (rw: 1 = read)
//   cpu_addr, cpu_wdata           register index and write data
//   cpu_rdata                     registered read data
//   mem_req, mem_we, mem_addr,    registered memory request, held
//   mem_wdata                     until mem_ack
//   mem_ack, mem_rdata            completion pulse and read data
// ADDR_W is expected to lie in 9..16 (ADDR_HI carries bits [ADDR_W-1:8]).
module gpu_bus_bridge
    import gpu_pkg::*;
#(
    parameter int         ADDR_W     = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] INC_RESET  = 8'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_strobe,
    input  logic              cpu_cs_n,
    input  logic              cpu_rw,
    input  logic [2:0]        cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);
    localparam int EW   = ADDR_W + 8;
    localparam int HI_W = ADDR_W - 8;

    logic                   acc, wr_acc, rd_acc, dport, data_wr, data_rd;
    logic                   push, pop, fifo_full, fifo_empty;
    logic [EW-1:0]          head;
    logic [1:0][ADDR_W-1:0] ptr;
    logic [1:0][7:0]        inc;
    logic                   sel, ovf;
    logic [7:0]             rd_mux;
    seq_state_t             state;

    assign acc     = cpu_strobe & ~cpu_cs_n;
    assign wr_acc  = acc & ~cpu_rw;
    assign rd_acc  = acc & cpu_rw;
    assign dport   = cpu_addr[0];  // DATA0 = 4, DATA1 = 5
    assign data_wr = wr_acc & ((cpu_addr == REG_DATA0) || (cpu_addr == REG_DATA1));
    assign data_rd = rd_acc & ((cpu_addr == REG_DATA0) || (cpu_addr == REG_DATA1));
    // Fullness is the registered flag, so a push in a full cycle is
    // dropped even when the same edge pops.
    assign push    = data_wr & ~fifo_full;
    assign pop     = (state == SEQ_WR) & mem_ack;

    gpu_write_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({ptr[dport], cpu_wdata}),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Pointer, increment and control registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
            inc <= {INC_RESET, INC_RESET};
            sel <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (wr_acc && cpu_addr == REG_CTRL) begin
                sel <= cpu_wdata[CTRL_SEL_BIT];
                if (cpu_wdata[CTRL_OVF_BIT]) ovf <= 1'b0;
            end
            if (wr_acc && cpu_addr == REG_INC)     inc[sel]             <= cpu_wdata;
            if (wr_acc && cpu_addr == REG_ADDR_LO) ptr[sel][7:0]        <= cpu_wdata;
            if (wr_acc && cpu_addr == REG_ADDR_HI) ptr[sel][ADDR_W-1:8] <= cpu_wdata[HI_W-1:0];
            if (push || data_rd) ptr[dport] <= ptr[dport] + ADDR_W'(inc[dport]);
            if (data_wr && fifo_full) ovf <= 1'b1;
        end
    end

`ifdef GPU_BUS_BRIDGE_READBACK_EN
    logic [1:0][7:0] pf;
    logic [1:0]      pf_vld, pf_pend, refetch;
    logic            rd_port, rd_stale, rd_sel;

    assign rd_sel = ~pf_pend[0];  // port 0 wins when both are pending

    // Anything that makes a port's prefetched byte out of date.
    always_comb begin
        refetch = 2'b00;
        if (push) refetch = 2'b11;
        if (wr_acc && (cpu_addr == REG_ADDR_LO || cpu_addr == REG_ADDR_HI)) refetch[sel] = 1'b1;
        if (data_rd) refetch[dport] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pf      <= '0;
            pf_vld  <= '0;
            pf_pend <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (refetch[n]) begin
                    pf_vld[n]  <= 1'b0;
                    pf_pend[n] <= 1'b1;
                end else if (state == SEQ_RD && mem_ack && !rd_stale && rd_port == 1'(n)) begin
                    pf[n]      <= mem_rdata;
                    pf_vld[n]  <= 1'b1;
                    pf_pend[n] <= 1'b0;
                end
            end
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    // Memory sequencer. Every request ends in IDLE, which leaves one idle
    // cycle between an ack and the next request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SEQ_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef GPU_BUS_BRIDGE_READBACK_EN
            rd_port   <= 1'b0;
            rd_stale  <= 1'b0;
`endif
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (!fifo_empty) begin
                        state     <= SEQ_WR;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= head[EW-1:8];
                        mem_wdata <= head[7:0];
                    end
`ifdef GPU_BUS_BRIDGE_READBACK_EN
                    else if (pf_pend != 2'b00) begin
                        state    <= SEQ_RD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ptr[rd_sel];
                        rd_port  <= rd_sel;
                        // Pointer moving on the issue edge: old address went out.
                        rd_stale <= refetch[rd_sel];
                    end
`endif
                end
                SEQ_WR: begin
                    if (mem_ack) begin
                        state   <= SEQ_IDLE;
                        mem_req <= 1'b0;
                    end
                end
`ifdef GPU_BUS_BRIDGE_READBACK_EN
                SEQ_RD: begin
                    if (refetch[rd_port]) rd_stale <= 1'b1;
                    if (mem_ack) begin
                        state   <= SEQ_IDLE;
                        mem_req <= 1'b0;
                    end
                end
`endif
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (cpu_addr)
            REG_CTRL:    rd_mux = {ovf, 6'b0, sel};
            REG_INC:     rd_mux = inc[sel];
            REG_ADDR_LO: rd_mux = ptr[sel][7:0];
            REG_ADDR_HI: rd_mux = 8'(ptr[sel][ADDR_W-1:8]);
`ifdef GPU_BUS_BRIDGE_READBACK_EN
            REG_DATA0, REG_DATA1: rd_mux = pf[dport];
`endif
            REG_STATUS: begin
                rd_mux[ST_FULL_BIT]  = fifo_full;
                rd_mux[ST_EMPTY_BIT] = fifo_empty;
                rd_mux[ST_OVF_BIT]   = ovf;
`ifdef GPU_BUS_BRIDGE_READBACK_EN
                rd_mux[ST_PF0_BIT]   = pf_vld[0];
                rd_mux[ST_PF1_BIT]   = pf_vld[1];
`endif
            end
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)        cpu_rdata <= 8'h00;
        else if (rd_acc) cpu_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_gpu_bus_bridge.sv
// tb_gpu_bus_bridge: directed bench for gpu_bus_bridge with a register-level
// model (pointers, increments, OVF, expected write queue, memory contents)
// and a bus responder that checks every completed request.
module tb_gpu_bus_bridge;
    localparam int         ADDR_W = 16;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] INC_RST = 8'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_strobe = 1'b0, cpu_cs_n = 1'b1, cpu_rw = 1'b0;
    logic [2:0]  cpu_addr = 3'd0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;

    always #5 clk = ~clk;

    gpu_bus_bridge #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .INC_RESET(INC_RST)) dut (
        .clk(clk), .rst(rst), .cpu_strobe(cpu_strobe), .cpu_cs_n(cpu_cs_n), .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic we; logic [15:0] addr; } tr_t;

    logic [15:0] m_ptr [2];
    logic [7:0]  m_inc [2];
    logic        m_sel, m_ovf;
    wr_t         exp_wr [$];   // accepted writes not yet popped by the bridge
    wr_t         wlog   [$];   // completed writes
    tr_t         tlog   [$];   // every completed request, in order
    logic [7:0]  mem_model [int];

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return mem_model.exists(int'(a)) ? mem_model[int'(a)] : 8'h00;
    endfunction

    task automatic model_reset();
        m_ptr[0] = 16'h0; m_ptr[1] = 16'h0;
        m_inc[0] = INC_RST; m_inc[1] = INC_RST;
        m_sel = 1'b0; m_ovf = 1'b0;
        exp_wr.delete();
    endtask

    // Runs on the access edge: expected read value, then register effects.
    task automatic model_step(input logic rw, input logic [2:0] a, input logic [7:0] d,
                              output logic [7:0] e, output logic [7:0] m);
        int p = int'(a[0]);
        e = 8'h00; m = 8'hFF;
        case (a)
            3'd0: e = {m_ovf, 6'b0, m_sel};
            3'd1: e = m_inc[m_sel];
            3'd2: e = m_ptr[m_sel][7:0];
            3'd3: e = m_ptr[m_sel][15:8];
            3'd6: e = {3'b0, m_ovf, 2'b00, exp_wr.size() == 0, exp_wr.size() == DEPTH};
            default: e = 8'h00;
        endcase
`ifdef GPU_BUS_BRIDGE_READBACK_EN
        if (a == 3'd4 || a == 3'd5) m = 8'h00;
        if (a == 3'd6) m = 8'hF3;
`endif
        if (!rw) begin
            case (a)
                3'd0: begin m_sel = d[0]; if (d[7]) m_ovf = 1'b0; end
                3'd1: m_inc[m_sel] = d;
                3'd2: m_ptr[m_sel][7:0] = d;
                3'd3: m_ptr[m_sel][15:8] = d;
                3'd4, 3'd5: begin
                    if (exp_wr.size() == DEPTH) m_ovf = 1'b1;
                    else begin
                        exp_wr.push_back({m_ptr[p], d});
                        m_ptr[p] = m_ptr[p] + 16'(m_inc[p]);
                    end
                end
                default: ;
            endcase
        end else if (a == 3'd4 || a == 3'd5) begin
            m_ptr[p] = m_ptr[p] + 16'(m_inc[p]);
        end
    endtask

    task automatic cpu_access(input logic rw, input logic [2:0] a, input logic [7:0] d,
                              output logic [7:0] v, output logic [7:0] e, output logic [7:0] m);
        @(negedge clk);
        cpu_strobe = 1'b1; cpu_cs_n = 1'b0; cpu_rw = rw; cpu_addr = a; cpu_wdata = d;
        @(posedge clk);
        model_step(rw, a, d, e, m);
        @(negedge clk);
        cpu_strobe = 1'b0; cpu_cs_n = 1'b1;
        v = cpu_rdata;
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] v, e, m;
        cpu_access(1'b0, a, d, v, e, m);
    endtask

    task automatic cpu_rd(input string name, input logic [2:0] a, output logic [7:0] v);
        logic [7:0] e, m;
        cpu_access(1'b1, a, 8'h00, v, e, m);
        if (m != 8'h00) chk(name, 32'(v & m), 32'(e & m));
    endtask

    // ---------------- memory responder / bus monitor ----------------
    logic        ack_en = 1'b0;
    int          ack_lat = 1, lat_cnt = 0;
    logic        prev_req = 1'b0, pop_pend = 1'b0;
    logic [24:0] prev_bus = '0;

    always @(negedge clk) begin
        if (!rst) begin
            mem_ack = 1'b0; lat_cnt = 0; prev_req = 1'b0; pop_pend = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0; lat_cnt = 0; prev_req = 1'b0;
            if (pop_pend) void'(exp_wr.pop_front());
            pop_pend = 1'b0;
            chk("no_back_to_back", 32'(mem_req), 32'd0);
        end else begin
            if (prev_req && mem_req) chk("req_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(prev_bus));
`ifndef GPU_BUS_BRIDGE_READBACK_EN
            if (mem_req) chk("mem_we_const", 32'(mem_we), 32'd1);
`endif
            prev_req = mem_req;
            prev_bus = {mem_we, mem_addr, mem_wdata};
            if (mem_req && ack_en) begin
                lat_cnt++;
                if (lat_cnt >= ack_lat) begin
                    mem_ack = 1'b1;
                    tlog.push_back({mem_we, mem_addr});
                    if (mem_we) begin
                        checks++;
                        if (exp_wr.size() == 0) begin
                            failures++;
                            $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_wdata);
                        end else begin
                            chk("wr_addr", 32'(mem_addr), 32'(exp_wr[0].addr));
                            chk("wr_data", 32'(mem_wdata), 32'(exp_wr[0].data));
                            pop_pend = 1'b1;
                        end
                        mem_model[int'(mem_addr)] = mem_wdata;
                        wlog.push_back({mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem_rd(mem_addr);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int quiet = 0;
        for (int i = 0; i < 600 && quiet < 6; i++) begin
            @(negedge clk);
            if (!mem_req && !mem_ack && exp_wr.size() == 0) quiet++;
            else quiet = 0;
        end
        chk(name, 32'(quiet >= 6), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v, lo, hi;
        int idx, got;
        model_reset();
        mem_model[16'h0100] = 8'h5A;
        mem_model[16'h0101] = 8'h5B;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_mem_req",   32'(mem_req),   32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        chk("rst_mem_addr",  32'(mem_addr),  32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        rst = 1'b1;
        cpu_rd("rst_status", 3'd6, v); chk("rst_status_lit", 32'(v), 32'h02);
        cpu_rd("rst_inc", 3'd1, v);    chk("rst_inc_lit", 32'(v), 32'h01);
        cpu_rd("rst_ctrl", 3'd0, v);

        // ---- posted writes with auto-increment ----
        ack_en = 1'b1; ack_lat = 1;
        cpu_wr(3'd2, 8'h00);
        cpu_wr(3'd3, 8'h18);
        cpu_wr(3'd1, 8'h02);
        idx = wlog.size();
        cpu_wr(3'd4, 8'hAA);
        cpu_wr(3'd4, 8'hBB);
        wait_idle("t1_drain");
        chk("t1_nwrites", 32'(wlog.size() - idx), 32'd2);
        if (wlog.size() >= idx + 2) begin
            chk("t1_w0", 32'(wlog[idx]),     32'h1800AA);
            chk("t1_w1", 32'(wlog[idx + 1]), 32'h1802BB);
        end
        cpu_rd("t1_lo", 3'd2, lo);
        cpu_rd("t1_hi", 3'd3, hi);
        chk("t1_ptr_lit", 32'({hi, lo}), 32'h1804);

        // ---- overflow with the bus stalled ----
        ack_en = 1'b0;
        cpu_wr(3'd0, 8'h01);
        for (int i = 0; i < 5; i++) cpu_wr(3'd5, 8'h10 + 8'(i));
        cpu_rd("t2_status", 3'd6, v);
        chk("t2_status_lit", 32'(v & 8'h13), 32'h11);
        cpu_rd("t2_lo", 3'd2, v);
        chk("t2_ptr1_lit", 32'(v), 32'h04);
        cpu_wr(3'd0, 8'h81);
        cpu_rd("t2_ovf_clr", 3'd6, v);
        chk("t2_ovf_clr_lit", 32'(v[4]), 32'd0);
        cpu_rd("t2_ctrl", 3'd0, v);
        idx = wlog.size();
        ack_en = 1'b1; ack_lat = 2;
        wait_idle("t2_drain");
        chk("t2_nwrites", 32'(wlog.size() - idx), 32'd4);
        if (wlog.size() >= idx + 4) chk("t2_last_lit", 32'(wlog[idx + 3]), 32'h000313);

        // ---- pointer wrap ----
        ack_lat = 1;
        cpu_wr(3'd0, 8'h00);
        cpu_wr(3'd3, 8'hFF);
        cpu_wr(3'd2, 8'hFF);
        cpu_wr(3'd1, 8'h01);
        cpu_wr(3'd4, 8'h77);
        cpu_rd("t3_lo", 3'd2, lo);
        cpu_rd("t3_hi", 3'd3, hi);
        chk("t3_wrap_lit", 32'({hi, lo}), 32'h0000);
        wait_idle("t3_drain");
        chk("t3_w_lit", 32'(wlog[wlog.size() - 1]), 32'hFFFF77);
`ifndef GPU_BUS_BRIDGE_READBACK_EN
        cpu_rd("t3_data_rd", 3'd4, v);
        cpu_rd("t3_lo_after_rd", 3'd2, v);
        chk("t3_rd_adv_lit", 32'(v), 32'h01);
        cpu_wr(3'd2, 8'h00);
`endif

`ifdef GPU_BUS_BRIDGE_READBACK_EN
        // ---- prefetch and readback ----
        cpu_wr(3'd3, 8'h01);
        cpu_wr(3'd2, 8'h00);
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            cpu_rd("t4_poll", 3'd6, v);
            if (v[2]) got = 1;
        end
        chk("t4_pf0_valid", 32'(got), 32'd1);
        cpu_rd("t4_data0", 3'd4, v);
        chk("t4_data0_lit", 32'(v), 32'h5A);
        cpu_rd("t4_lo", 3'd2, v);
        chk("t4_ptr_lit", 32'(v), 32'h01);
        wait_idle("t4_idle");
        chk("t4_refetch_lit", 32'(tlog[tlog.size() - 1]), 32'h00101);
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            cpu_rd("t4_poll2", 3'd6, v);
            if (v[2]) got = 1;
        end
        cpu_rd("t4_data0b", 3'd4, v);
        chk("t4_data0b_lit", 32'(v), 32'h5B);
        wait_idle("t4_idle2");

        // ---- writes hold off prefetch; ports refetched in order ----
        ack_en = 1'b0;
        idx = tlog.size();
        cpu_wr(3'd5, 8'hC1);
        cpu_wr(3'd5, 8'hC2);
        ack_en = 1'b1;
        wait_idle("t5_drain");
        chk("t5_ntrans", 32'(tlog.size() - idx), 32'd4);
        if (tlog.size() >= idx + 4) begin
            chk("t5_t0_we", 32'(tlog[idx].we),     32'd1);
            chk("t5_t1_we", 32'(tlog[idx + 1].we), 32'd1);
            chk("t5_rd0",   32'(tlog[idx + 2]),    32'({1'b0, m_ptr[0]}));
            chk("t5_rd1",   32'(tlog[idx + 3]),    32'({1'b0, m_ptr[1]}));
        end
`endif

        // ---- reset while a request is outstanding ----
        ack_en = 1'b0;
        cpu_wr(3'd1, 8'h05);
        cpu_wr(3'd4, 8'h99);
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (mem_req) got = 1;
        end
        chk("t6_req_seen", 32'(got), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_req_drop", 32'(mem_req), 32'd0);
        chk("t6_rdata", 32'(cpu_rdata), 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        model_reset();
        cpu_rd("t6_status", 3'd6, v);
        chk("t6_status_lit", 32'(v), 32'h02);
        cpu_rd("t6_inc", 3'd1, v);
        chk("t6_inc_lit", 32'(v), 32'(INC_RST));
        repeat (5) @(negedge clk);
        chk("t6_bus_quiet", 32'(mem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
